// File: rtl/sr_drift_sequencer.sv
// Schumann Resonance drift sequencer: one shared LFSR/step engine walks every
// harmonic's drift offset in round-robin and exposes centre+drift to the bank.

module sr_drift_slot #(
  parameter int WIDTH   = 18,
  parameter int CEN_RST = 0,
  parameter int MAX_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_field_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  input  logic             step_we_i,
  input  logic [WIDTH-1:0] step_drift_i,
  output logic [WIDTH-1:0] drift_o,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] omega_o
);
  logic signed [WIDTH-1:0] cen_q, cen_d, max_q, max_d, drf_q, drf_d;
  logic                    frz_q, frz_d;
  logic signed [WIDTH:0]   dx, wmax;

  always_comb begin
    cen_d = cen_q;
    max_d = max_q;
    drf_d = drf_q;
    frz_d = frz_q;
    dx    = {drf_q[WIDTH-1], drf_q};
    // the bound is a magnitude; negative writes collapse to zero
    wmax  = cfg_data_i[WIDTH-1] ? '0 : {1'b0, cfg_data_i};
    if (cfg_we_i) begin
      case (cfg_field_i)
        2'd0: cen_d = cfg_data_i;
        2'd1: begin
          max_d = wmax[WIDTH-1:0];
          if (dx > wmax)       drf_d = wmax[WIDTH-1:0];
          else if (dx < -wmax) drf_d = -wmax[WIDTH-1:0];
        end
        2'd2: frz_d = cfg_data_i[0];
        default: ;
      endcase
    end else if (step_we_i && !frz_q) begin
      drf_d = step_drift_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_q <= WIDTH'(CEN_RST);
      max_q <= WIDTH'(MAX_RST);
      drf_q <= '0;
      frz_q <= 1'b0;
    end else begin
      cen_q <= cen_d;
      max_q <= max_d;
      drf_q <= drf_d;
      frz_q <= frz_d;
    end
  end

  assign drift_o = drf_q;
  assign max_o   = max_q;
  assign omega_o = cen_q + drf_q;
endmodule

module sr_drift_sequencer #(
  parameter int WIDTH             = 18,
  parameter int NUM_HARMONICS     = 5,
  parameter int FAST_SIM          = 0,
  parameter int UPDATE_PERIOD_OVR = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_en,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [2:0]                       cfg_addr,
  input  logic [1:0]                       cfg_field,
  input  logic [WIDTH-1:0]                 cfg_data,
  output logic [NUM_HARMONICS*WIDTH-1:0]   omega_dt_packed,
  output logic [NUM_HARMONICS*WIDTH-1:0]   drift_offset_packed,
  output logic                             walk_busy,
  output logic                             sweep_done,
  output logic                             overrun
);
  localparam int N = NUM_HARMONICS;
  localparam logic [21:0] PERIOD = (UPDATE_PERIOD_OVR != 0) ? 22'(UPDATE_PERIOD_OVR) :
                                   (FAST_SIM != 0) ? 22'd400 : 22'd960000;
  localparam logic [2:0] LAST = 3'(N - 1);

  function automatic int cen_rst(input int h);
    case (h)
      0: return 196;
      1: return 354;
      2: return 514;
      3: return 643;
      default: return 823;
    endcase
  endfunction

  function automatic int max_rst(input int h);
    case (h)
      0: return 23;
      1: return 28;
      2: return 39;
      3: return 58;
      default: return 77;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

  state_e                  state_q, state_d;
  logic [21:0]             cnt_q, cnt_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [2:0]              idx_q, idx_d;
  logic                    pend_q, pend_d, ovr_q, ovr_d, done_q, done_d;
  logic                    tick, fb;
  logic [N-1:0][WIDTH-1:0] drift, maxv, omega;
  logic [N-1:0]            cfg_we, step_we;
  logic signed [WIDTH:0]   cur, lim, stp, up, dn, nxt;
  logic [WIDTH-1:0]        step_drift;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clk_en) begin
      if (cnt_q == PERIOD) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 22'd1;
      end
    end
  end

  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // A tick landing in DONE is folded into pending before DONE consumes it,
  // so back-to-back sweeps never leave a stale pending flag in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    if (tick && pend_q)            ovr_d  = 1'b1;
    if (tick && state_q != IDLE)   pend_d = 1'b1;
    if (clk_en) begin
      case (state_q)
        IDLE: if (tick) begin
          state_d = WALK;
          idx_d   = '0;
        end
        WALK: begin
          lfsr_d = {lfsr_q[14:0], fb};
          if (idx_q == LAST) state_d = DONE;
          else               idx_d   = idx_q + 3'd1;
        end
        DONE: begin
          done_d = 1'b1;
          idx_d  = '0;
          pend_d = 1'b0;
          state_d = (pend_q || tick) ? WALK : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // shared step/reflect engine, operating on the slot selected by idx
  always_comb begin
    cur = '0;
    lim = '0;
    for (int h = 0; h < N; h++) begin
      if (idx_q == 3'(h)) begin
        cur = {drift[h][WIDTH-1], drift[h]};
        lim = {1'b0, maxv[h]};
      end
    end
    stp = (WIDTH+1)'({1'b0, lfsr_q[3:2]}) + (WIDTH+1)'(1);
    up  = cur + stp;
    dn  = cur - stp;
    if (lfsr_q[0]) nxt = (up <= lim)  ? up : dn;
    else           nxt = (dn >= -lim) ? dn : up;
    if (nxt > lim)       nxt = lim;
    else if (nxt < -lim) nxt = -lim;
    step_drift = nxt[WIDTH-1:0];
  end

  assign cfg_ready = (state_q == IDLE) && !pend_q;

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign cfg_we[g]  = cfg_valid && cfg_ready && (cfg_addr == 3'(g));
    assign step_we[g] = clk_en && (state_q == WALK) && (idx_q == 3'(g));
    sr_drift_slot #(
      .WIDTH   (WIDTH),
      .CEN_RST (cen_rst(g)),
      .MAX_RST (max_rst(g))
    ) u_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_we_i     (cfg_we[g]),
      .cfg_field_i  (cfg_field),
      .cfg_data_i   (cfg_data),
      .step_we_i    (step_we[g]),
      .step_drift_i (step_drift),
      .drift_o      (drift[g]),
      .max_o        (maxv[g]),
      .omega_o      (omega[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= 16'hB5C3;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
    end
  end

  assign omega_dt_packed     = omega;
  assign drift_offset_packed = drift;
  assign walk_busy           = (state_q != IDLE);
  assign sweep_done          = done_q;
  assign overrun             = ovr_q;
endmodule

// File: tb/tb_sr_drift_sequencer.sv
// Randomized bench for sr_drift_sequencer against a behavioural sweep model.
module tb_sr_drift_sequencer;
  localparam int W = 18;
  localparam int N = 5;
  localparam int P = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           clk_en = 1'b0, cfg_valid = 1'b0;
  logic [2:0]     cfg_addr = '0;
  logic [1:0]     cfg_field = '0;
  logic [W-1:0]   cfg_data = '0;
  logic [N*W-1:0] omega_dt_packed, drift_offset_packed;
  logic           cfg_ready, walk_busy, sweep_done, overrun;

  logic           en_b = 1'b0;
  logic [N*W-1:0] omega_b, drift_b;
  logic           ready_b, busy_b, done_b, ovr_b;

  sr_drift_sequencer #(.WIDTH(W), .NUM_HARMONICS(N), .FAST_SIM(1), .UPDATE_PERIOD_OVR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .omega_dt_packed(omega_dt_packed), .drift_offset_packed(drift_offset_packed),
    .walk_busy(walk_busy), .sweep_done(sweep_done), .overrun(overrun));

  sr_drift_sequencer #(.WIDTH(W), .NUM_HARMONICS(N), .FAST_SIM(0), .UPDATE_PERIOD_OVR(2)) u_ovr (
    .clk(clk), .rst_n(rst_n), .clk_en(en_b), .cfg_valid(1'b0), .cfg_ready(ready_b),
    .cfg_addr(3'd0), .cfg_field(2'd0), .cfg_data('0),
    .omega_dt_packed(omega_b), .drift_offset_packed(drift_b),
    .walk_busy(busy_b), .sweep_done(done_b), .overrun(ovr_b));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Model: pos -1 = no sweep, 0..N-1 = next slot to walk, N = finishing sweep
  int m_cen[N], m_max[N], m_drf[N];
  bit m_frz[N];
  int m_lfsr, m_cnt, m_pos;
  bit m_pend, m_ovr, m_done;

  task automatic m_reset();
    int rc[N] = '{196, 354, 514, 643, 823};
    int rm[N] = '{23, 28, 39, 58, 77};
    for (int h = 0; h < N; h++) begin
      m_cen[h] = rc[h]; m_max[h] = rm[h]; m_drf[h] = 0; m_frz[h] = 0;
    end
    m_lfsr = 'hB5C3; m_cnt = 0; m_pos = -1; m_pend = 0; m_ovr = 0; m_done = 0;
  endtask

  task automatic m_walk(input int h);
    int s  = 1 + ((m_lfsr >> 2) & 3);
    int d  = m_drf[h];
    int mx = m_max[h];
    int fb;
    if (!m_frz[h]) begin
      if (m_lfsr & 1) d = (d + s <= mx) ? d + s : d - s;
      else            d = (d - s >= -mx) ? d - s : d + s;
      if (d > mx)  d = mx;
      if (d < -mx) d = -mx;
      m_drf[h] = d;
    end
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
  endtask

  task automatic m_edge(input bit en, input bit v, input int a, input int f, input int dat);
    int op = m_pos;
    bit pp = m_pend;
    bit tk = 0;
    m_done = 0;
    if (v && op < 0 && !pp && a < N) begin
      case (f)
        0: m_cen[a] = dat;
        1: begin
          m_max[a] = (dat < 0) ? 0 : dat;
          if (m_drf[a] > m_max[a])  m_drf[a] = m_max[a];
          if (m_drf[a] < -m_max[a]) m_drf[a] = -m_max[a];
        end
        2: m_frz[a] = dat & 1;
        default: ;
      endcase
    end
    if (en) begin
      if (m_cnt == P) begin tk = 1; m_cnt = 0; end
      else m_cnt++;
      if (tk && pp) m_ovr = 1;
      if (op < 0) begin
        if (tk) m_pos = 0;
      end else if (op < N) begin
        m_walk(op);
        m_pos = op + 1;
        if (tk) m_pend = 1;
      end else begin
        m_done = 1;
        m_pos  = (pp || tk) ? 0 : -1;
        m_pend = 0;
      end
    end
  endtask

  task automatic cmp_all();
    for (int h = 0; h < N; h++) begin
      chk($sformatf("omega%0d", h), sx(omega_dt_packed[h*W +: W]), m_cen[h] + m_drf[h]);
      chk($sformatf("drift%0d", h), sx(drift_offset_packed[h*W +: W]), m_drf[h]);
    end
    chk("ready", int'(cfg_ready), int'(m_pos < 0 && !m_pend));
    chk("busy", int'(walk_busy), int'(m_pos >= 0));
    chk("done", int'(sweep_done), int'(m_done));
    chk("ovr", int'(overrun), int'(m_ovr));
  endtask

  task automatic cyc(input bit en, input bit v, input int a, input int f, input int dat);
    clk_en    = en;
    cfg_valid = v;
    cfg_addr  = 3'(a);
    cfg_field = 2'(f);
    cfg_data  = W'(dat);
    @(posedge clk);
    m_edge(en, v, a, f, dat);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic chk_reset(input string t);
    int rc[N] = '{196, 354, 514, 643, 823};
    for (int h = 0; h < N; h++) begin
      chk({t, "_omega"}, sx(omega_dt_packed[h*W +: W]), rc[h]);
      chk({t, "_drift"}, sx(drift_offset_packed[h*W +: W]), 0);
    end
    chk({t, "_ready"}, int'(cfg_ready), 1);
    chk({t, "_busy"}, int'(walk_busy), 0);
    chk({t, "_done"}, int'(sweep_done), 0);
    chk({t, "_ovr"}, int'(overrun), 0);
  endtask

  initial begin
    int seen, pulses, budget, expv, nsw, dat, f;
    bit en, v;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    m_reset();

    // first sweep from the reset LFSR seed
    for (int k = 0; k < P; k++) cyc(1, 0, 0, 0, 0);
    chk("pretick_busy", int'(walk_busy), 0);
    cyc(1, 0, 0, 0, 0);
    chk("tick_busy", int'(walk_busy), 1);
    seen = 0; pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (sweep_done) begin
        pulses++;
        if (seen == 0) seen = k;
      end
    end
    chk("done_lat", seen, 6);
    chk("done_cnt", pulses, 1);
    chk("sw1_d0", sx(drift_offset_packed[0 +: W]), 1);
    chk("sw1_d1", sx(drift_offset_packed[W +: W]), -2);

    // clamp on max write: walk until |drift2| > 5 while idle
    budget = 0;
    while (!(m_pos < 0 && !m_pend && (m_drf[2] > 5 || m_drf[2] < -5)) && budget < 20000) begin
      cyc(1, 0, 0, 0, 0);
      budget++;
    end
    chk("clamp_wait", int'(budget < 20000), 1);
    expv = (m_drf[2] > 0) ? 5 : -5;
    cyc(1, 1, 2, 1, 5);
    chk("clamp_d2", sx(drift_offset_packed[2*W +: W]), expv);

    // zero bound on h0 pins its drift for 20 sweeps
    budget = 0;
    while (!(m_pos < 0 && !m_pend) && budget < 1000) begin cyc(1, 0, 0, 0, 0); budget++; end
    cyc(1, 1, 0, 1, 0);
    chk("bound_clip", sx(drift_offset_packed[0 +: W]), 0);
    nsw = 0; budget = 0;
    while (nsw < 20 && budget < 9000) begin
      cyc(1, 0, 0, 0, 0);
      budget++;
      if (sweep_done) begin
        nsw++;
        chk("bound_d0", sx(drift_offset_packed[0 +: W]), 0);
        chk("bound_om0", sx(omega_dt_packed[0 +: W]), 196);
      end
    end
    chk("bound_sweeps", nsw, 20);

    // reset in the middle of a sweep
    budget = 0;
    while (m_pos != 2 && budget < 1000) begin cyc(1, 0, 0, 0, 0); budget++; end
    chk("midsweep_wait", int'(walk_busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // random clk_en gaps with config traffic, including writes held across sweeps
    for (int k = 0; k < 4000; k++) begin
      en = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 2) == 0);
      f  = int'($urandom_range(0, 3));
      if (f == 0)      dat = int'($urandom_range(0, 4000)) - 2000;
      else if (f == 1) dat = int'($urandom_range(0, 120)) - 20;
      else             dat = int'($urandom_range(0, 1));
      cyc(en, v, int'($urandom_range(0, 7)), f, dat);
    end

    // period 2: ticks saturate, sweeps chain back to back
    clk_en = 1'b0; cfg_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en_b = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_b) pulses++;
      if (k == 8) chk("ovr_early", int'(ovr_b), 0);
      if (k >= 3) chk("ovr_busy", int'(busy_b), 1);
      if (k >= 6) chk("ovr_ready", int'(ready_b), 0);
    end
    chk("ovr_flag", int'(ovr_b), 1);
    chk("ovr_sweeps", pulses, 9);
    en_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_drift_sequencer.md
# sr_drift_sequencer

Time-multiplexed scheduler for the Schumann Resonance frequency random walk. A single shared LFSR and step/reflect adder serves all harmonics in round-robin, instead of one engine per harmonic. A valid/ready configuration port lets the host retune per-harmonic centre, drift bound and freeze state. The block sits between the host control register file and the SR oscillator bank, and drives the bank's packed OMEGA_DT inputs.

## Interface
- WIDTH, 18, signed Q14 word width of omega/drift values
- NUM_HARMONICS, 5, number of harmonics served (1..5)
- FAST_SIM, 0, nonzero selects the 400-cycle default update period, else 960000
- UPDATE_PERIOD_OVR, 0, nonzero overrides the update period (22-bit)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  4 kHz sample strobe; all walk/counter activity is gated by it
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted this cycle when high with cfg_valid
- cfg_addr  in  3  harmonic index
- cfg_field  in  2  0=centre, 1=drift max, 2=freeze (cfg_data[0]), 3=reserved
- cfg_data  in  WIDTH  write data (signed)
- omega_dt_packed  out  NUM_HARMONICS*WIDTH  centre+drift per harmonic, h0 in LSBs
- drift_offset_packed  out  NUM_HARMONICS*WIDTH  drift per harmonic
- walk_busy  out  1  sweep in progress
- sweep_done  out  1  one-clk pulse at end of each sweep
- overrun  out  1  sticky; set when a tick arrives while one is already pending

## Operation
- Reset: centres {196,354,514,643,823}; max {23,28,39,58,77} (index h uses entry h); drift=0; freeze=0; LFSR=16'hB5C3; counter=0; state IDLE; pending=0; overrun=0; walk_busy=0; sweep_done=0; cfg_ready=1.
- Period P = UPDATE_PERIOD_OVR if nonzero, else 400 (FAST_SIM) or 960000. The counter increments on each clk_en. At counter==P it produces a tick and wraps to 0, so ticks are P+1 clk_en apart.
- Tick in IDLE: go to WALK with idx=0. Tick outside IDLE: set pending. Tick while pending=1: set overrun; the pending flag stays 1 (ticks do not queue).
- FSM states: IDLE, WALK, DONE.
  - WALK: on each clk_en, update drift[idx] and advance the LFSR, then idx++. After idx=N-1, go to DONE.
  - DONE: on the next clk_en, pulse sweep_done for that clk cycle. Go to WALK with idx=0 if pending (and clear pending), else go to IDLE.
- Per-step rule: dir=lfsr[0]; step=1+lfsr[3:2] (range 1..4); LFSR shifts left with fb=lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] into bit 0.
  - dir=1: if d+step<=max, d=d+step; else d=d-step.
  - dir=0: if d-step>=-max, d=d-step; else d=d+step.
  - The result is then clamped to [-max,+max].
- Frozen harmonic: the LFSR still advances for that slot; drift is held.
- All sums use WIDTH+1 bits internally; outputs are WIDTH bits. Max is treated as non-negative: a negative write stores 0.
- Config handshake:
  - cfg_ready = (state==IDLE) && !pending.
  - A transfer occurs on any clk edge where cfg_valid && cfg_ready, independent of clk_en.
  - cfg_addr>=N or field 3: accepted, no effect.
  - Max write: stores the new max. If |drift| exceeds it, drift clamps to ±new max in the same cycle.
  - Centre write: visible on omega_dt_packed the next cycle.
- Reset mid-sweep: all state returns to reset values immediately, and the partial sweep is discarded.

## Timing
- Outputs are registered and combinationally derived from registers (omega = centre + drift).
- Drift update latency is 1 clk after the clk_en in which the slot is processed.
- The sweep occupies N+1 clk_en cycles after the tick: N WALK cycles plus 1 DONE cycle.
- walk_busy is high in WALK and DONE.
- A tick and a cfg transfer in the same cycle while in IDLE: the cfg write applies first, and the sweep starts that same clk_en. cfg_ready drops on the next clk.

## Test plan
- Reset: hold rst_n=0, then release. Require omega_dt_packed={823,643,514,354,196} (h4..h0), drift all 0, cfg_ready=1, walk_busy=0.
- First sweep, FAST_SIM=1: 401 clk_en → tick. Require drift0=+1 (LFSR B5C3: dir=1, step=1) and drift1=-2 (LFSR 6B86: dir=0, step=2). sweep_done pulses once, 6 clk_en after the tick.
- Bound: cfg h0 max=0, then run 20 sweeps. Require drift0==0 throughout and omega0==196.
- Clamp on write: force drift2=+10 via sweeps (or preload), then write max2=5. Require drift2=+5 on the next cycle.
- Handshake: hold cfg_valid during a sweep. Require cfg_ready=0 until the cycle after DONE→IDLE, then exactly one write is taken.
- Overrun: UPDATE_PERIOD_OVR=2, N=5. Require pending back-to-back sweeps, overrun=1, and walk_busy never dropping once ticks saturate.
